// File: rtl/psum_accumulator_pkg.sv
// Shared types and helpers for the partial-sum accumulator.
// Holds the FSM state encoding, lane width constants and the saturating add.
package psum_accumulator_pkg;

  typedef enum logic [1:0] {
    PA_IDLE  = 2'd0,
    PA_ACCUM = 2'd1,
    PA_DRAIN = 2'd2
  } pa_state_e;

  // Default geometry of one psum word.
  localparam int PA_DEF_COL     = 4;
  localparam int PA_DEF_PSUM_BW = 16;

  // Widest lane the saturating helper can handle, plus one guard bit.
  localparam int PA_MAX_BW  = 32;
  localparam int PA_WIDE_BW = PA_MAX_BW + 1;

  typedef logic signed [PA_WIDE_BW-1:0] pa_wide_t;

  // Clamp a (bw+1)-bit signed sum, carried in a wide container, to signed bw bits.
  function automatic pa_wide_t sat_add(input pa_wide_t sum, input int bw);
    pa_wide_t one;
    pa_wide_t max_v;
    pa_wide_t min_v;
    one   = pa_wide_t'(1);
    max_v = (one <<< (bw - 1)) - one;
    min_v = -(one <<< (bw - 1));
    if (sum > max_v) begin
      return max_v;
    end else if (sum < min_v) begin
      return min_v;
    end
    return sum;
  endfunction

endpackage

// File: rtl/psum_lane_sat_add.sv
// One signed lane of the accumulator: either passes the new value through
// (first iteration) or adds it to the stored value with saturation.
module psum_lane_sat_add
  import psum_accumulator_pkg::*;
#(
  parameter int psum_bw = PA_DEF_PSUM_BW
) (
  input  logic signed [psum_bw-1:0] acc_in,
  input  logic signed [psum_bw-1:0] add_in,
  input  logic                      overwrite,
  output logic signed [psum_bw-1:0] sum_out
);

  logic signed [psum_bw:0] raw_sum;

  // Add at one extra bit so the carry is never lost, then saturate back down.
  always_comb begin
    raw_sum = (psum_bw + 1)'(acc_in) + (psum_bw + 1)'(add_in);
    if (overwrite) begin
      sum_out = add_in;
    end else begin
      sum_out = psum_bw'(sat_add(pa_wide_t'(raw_sum), psum_bw));
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: captures column psum words for every kernel-offset
// iteration, sums them element-wise in a register buffer, then drains the
// final sums one word per handshake.
// Optional macro PSUM_ACC_RELU_EN clamps negative lanes to 0 on the drain path.
module psum_accumulator
  import psum_accumulator_pkg::*;
#(
  parameter int col     = PA_DEF_COL,
  parameter int psum_bw = PA_DEF_PSUM_BW,
  parameter int num_out = 8,
  parameter int kij_len = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [col*psum_bw-1:0]   in_data,
  input  logic                     iter_done,
  input  logic                     compute_done,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [col*psum_bw-1:0]   out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     err_overflow
);

  localparam int W      = col * psum_bw;
  localparam int PTR_W  = $clog2(num_out + 1);
  localparam int IDX_W  = (num_out > 1) ? $clog2(num_out) : 1;
  localparam int ITER_W = (kij_len > 1) ? $clog2(kij_len) : 1;

  pa_state_e        state_q, state_d;
  logic             start_q;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic [W-1:0]     buf_q [num_out];
  logic [W-1:0]     buf_d [num_out];

  logic             start_rise;
  logic             wr_full;
  logic             iter_last;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_next;
  logic [W-1:0]     acc_word;
  logic [W-1:0]     sum_word;

  assign start_rise = start && !start_q;
  assign wr_full    = (wr_ptr_q == PTR_W'(num_out));
  assign iter_last  = (iter_q == ITER_W'(kij_len - 1));
  assign wr_idx     = wr_ptr_q[IDX_W-1:0];
  assign rd_next    = rd_ptr_q + IDX_W'(1);
  assign acc_word   = buf_q[wr_idx];

  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign out_data     = out_data_q;
  assign err_overflow = err_q;
  assign busy         = (state_q != PA_IDLE);

  for (genvar i = 0; i < col; i++) begin : g_lane
    psum_lane_sat_add #(
      .psum_bw (psum_bw)
    ) u_lane (
      .acc_in    (acc_word[i*psum_bw +: psum_bw]),
      .add_in    (in_data[i*psum_bw +: psum_bw]),
      .overwrite (iter_q == '0),
      .sum_out   (sum_word[i*psum_bw +: psum_bw])
    );
  end

  // Drain-side view of a stored word; the buffer itself is never modified here.
  function automatic logic [W-1:0] drain_view(input logic [W-1:0] w);
    logic [W-1:0] r;
    r = w;
`ifdef PSUM_ACC_RELU_EN
    for (int i = 0; i < col; i++) begin
      if (w[i*psum_bw + psum_bw - 1]) begin
        r[i*psum_bw +: psum_bw] = '0;
      end
    end
`endif
    return r;
  endfunction

  // Next-state logic for the FSM, pointers, buffer and registered drain outputs.
  always_comb begin
    state_d     = state_q;
    iter_d      = iter_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    buf_d       = buf_q;

    if (start_rise) begin
      state_d     = PA_ACCUM;
      iter_d      = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      err_d       = 1'b0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_data_d  = '0;
    end else begin
      case (state_q)
        PA_IDLE: begin
          if (in_valid) begin
            err_d = 1'b1;
          end
        end
        PA_ACCUM: begin
          if (in_valid) begin
            if (wr_full) begin
              err_d = 1'b1;
            end else begin
              buf_d[wr_idx] = sum_word;
              wr_ptr_d      = wr_ptr_q + PTR_W'(1);
            end
          end
          if (iter_done) begin
            wr_ptr_d = '0;
            if (iter_last) begin
              err_d = 1'b1;
            end else begin
              iter_d = iter_q + ITER_W'(1);
            end
          end
          if (compute_done) begin
            state_d  = PA_DRAIN;
            rd_ptr_d = '0;
          end
        end
        PA_DRAIN: begin
          if (in_valid) begin
            err_d = 1'b1;
          end
          if (!out_valid_q) begin
            out_valid_d = 1'b1;
            out_data_d  = drain_view(buf_q[rd_ptr_q]);
            out_last_d  = (rd_ptr_q == IDX_W'(num_out - 1));
          end else if (out_ready) begin
            if (out_last_q) begin
              state_d     = PA_IDLE;
              out_valid_d = 1'b0;
              out_last_d  = 1'b0;
            end else begin
              rd_ptr_d   = rd_next;
              out_data_d = drain_view(buf_q[rd_next]);
              out_last_d = (rd_next == IDX_W'(num_out - 1));
            end
          end
        end
        default: begin
          state_d = PA_IDLE;
        end
      endcase
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= PA_IDLE;
      start_q     <= 1'b0;
      iter_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      iter_q      <= iter_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  // Accumulation buffer; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench for psum_accumulator against a behavioural model that
// keeps the running sums as plain integers with explicit saturation.
module tb_psum_accumulator;

  localparam int COL  = 4;
  localparam int BW   = 16;
  localparam int NOUT = 8;
  localparam int KIJ  = 9;
  localparam int W    = COL * BW;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         iter_done;
  logic         compute_done;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;
  logic         err_overflow;

  int checks   = 0;
  int failures = 0;

  // Reference model: spec-level state of the accumulator.
  int   mbuf [NOUT][COL];
  int   m_mode;
  int   m_iter;
  int   m_wr;
  logic m_err;
  logic [W-1:0] got [NOUT];

  always #5 clk = ~clk;

  psum_accumulator #(
    .col     (COL),
    .psum_bw (BW),
    .num_out (NOUT),
    .kij_len (KIJ)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .iter_done    (iter_done),
    .compute_done (compute_done),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy),
    .err_overflow (err_overflow)
  );

  // Count one comparison and report it if the values disagree.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic logic [W-1:0] expWord(input int w);
    logic [W-1:0] r;
    int v;
    r = '0;
    for (int l = 0; l < COL; l++) begin
      v = mbuf[w][l];
`ifdef PSUM_ACC_RELU_EN
      if (v < 0) v = 0;
`endif
      r[l*BW +: BW] = v[BW-1:0];
    end
    return r;
  endfunction

  // Drive one cycle of input and update the model with what the spec says happens.
  task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic done);
    int lane;
    in_valid  = v;
    in_data   = d;
    iter_done = done;
    if (m_mode == 1) begin
      if (v) begin
        if (m_wr == NOUT) begin
          m_err = 1'b1;
        end else begin
          for (int l = 0; l < COL; l++) begin
            lane = $signed(d[l*BW +: BW]);
            mbuf[m_wr][l] = (m_iter == 0) ? lane : sat(mbuf[m_wr][l] + lane);
          end
          m_wr++;
        end
      end
      if (done) begin
        m_wr = 0;
        if (m_iter == KIJ - 1) m_err = 1'b1;
        else m_iter++;
      end
    end else if (v) begin
      m_err = 1'b1;
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    iter_done = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    m_mode = 1;
    m_iter = 0;
    m_wr   = 0;
    m_err  = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    m_mode = 0;
    m_iter = 0;
    m_wr   = 0;
    m_err  = 1'b0;
  endtask

  // Eight words of one iteration; fixed pattern or random, iter_done merged or separate.
  task automatic sendIteration(input bit rnd, input logic [W-1:0] fixed, input bit merge, input bit with_done);
    logic [W-1:0] d;
    for (int w = 0; w < NOUT; w++) begin
      d = rnd ? {$urandom, $urandom} : fixed;
      applyStimulus(1'b1, d, merge && with_done && (w == NOUT - 1));
    end
    if (with_done && !merge) applyStimulus(1'b0, '0, 1'b1);
  endtask

  // ready_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  task automatic drainAndCheck(input int ready_mode);
    int   idx;
    int   cyc;
    int   first;
    int   last_cyc;
    int   vcnt;
    bit   held;
    logic [W-1:0] held_data;
    logic held_last;
    logic r;
    int   pat [4];
    pat = '{1, 0, 0, 1};
    compute_done = 1'b1;
    @(posedge clk);
    #1;
    m_mode = 2;
    checkOutput("drain_latency_valid", out_valid, 1'b0);
    checkOutput("drain_busy", busy, 1'b1);
    idx = 0; cyc = 0; first = -1; last_cyc = 0; vcnt = 0; held = 0;
    held_data = '0; held_last = 1'b0;
    while (idx < NOUT && cyc < 200) begin
      case (ready_mode)
        0:       r = 1'b1;
        1:       r = pat[vcnt % 4] != 0;
        default: r = $urandom_range(0, 1) != 0;
      endcase
      out_ready = r;
      if (out_valid) begin
        if (first < 0) first = cyc;
        if (held) begin
          checkOutput("stall_hold_data", out_data, held_data);
          checkOutput("stall_hold_last", out_last, held_last);
        end
        if (r) begin
          got[idx] = out_data;
          checkOutput($sformatf("drain_data%0d", idx), out_data, expWord(idx));
          checkOutput($sformatf("drain_last%0d", idx), out_last, idx == NOUT - 1);
          idx++;
          held = 0;
          last_cyc = cyc;
        end else begin
          held = 1;
          held_data = out_data;
          held_last = out_last;
        end
        vcnt++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    out_ready = 1'b0;
    if (idx < NOUT) checkOutput("drain_timeout", idx, NOUT);
    checkOutput("busy_after_drain", busy, 1'b0);
    checkOutput("valid_after_drain", out_valid, 1'b0);
    if (ready_mode == 0) checkOutput("full_throughput", last_cyc - first + 1, NOUT);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("compute_done_held_idle", busy, 1'b0);
    compute_done = 1'b0;
    m_mode = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    iter_done = 1'b0; compute_done = 1'b0; out_ready = 1'b0;
    m_mode = 0; m_iter = 0; m_wr = 0; m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    doReset();

    // Reset state
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_out_last", out_last, 1'b0);
    checkOutput("rst_out_data", out_data, '0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_err", err_overflow, 1'b0);

    // Word while idle is an error
    applyStimulus(1'b1, {$urandom, $urandom}, 1'b0);
    checkOutput("idle_word_err", err_overflow, 1'b1);

    // All lanes 1 for 9 iterations, alternating merged/separate iter_done
    pulseStart();
    checkOutput("start_clears_err", err_overflow, 1'b0);
    checkOutput("busy_accum", busy, 1'b1);
    for (int it = 0; it < KIJ; it++) sendIteration(1'b0, 64'h0001_0001_0001_0001, it % 2 == 1, it < KIJ - 1);
    checkOutput("ones_err", err_overflow, m_err);
    drainAndCheck(0);
    checkOutput("ones_sum_nine", got[3], 64'h0009_0009_0009_0009);

    // Saturation: lane0 +20000 and lane1 -20000 twice
    pulseStart();
    sendIteration(1'b0, {16'd0, 16'd0, 16'hB1E0, 16'h4E20}, 1'b0, 1'b1);
    sendIteration(1'b0, {16'd0, 16'd0, 16'hB1E0, 16'h4E20}, 1'b0, 1'b0);
    drainAndCheck(0);
    checkOutput("sat_pos", got[0][15:0], 16'h7FFF);
`ifdef PSUM_ACC_RELU_EN
    checkOutput("sat_neg", got[0][31:16], 16'h0000);
`else
    checkOutput("sat_neg", got[0][31:16], 16'h8000);
`endif

    // Merged word/iter_done at wr_ptr 7 then next iteration from buf[0]
    pulseStart();
    sendIteration(1'b1, '0, 1'b1, 1'b1);
    sendIteration(1'b1, '0, 1'b0, 1'b0);
    checkOutput("merge_err", err_overflow, 1'b0);
    drainAndCheck(2);

    // Ninth word dropped, error sticky until next start
    pulseStart();
    sendIteration(1'b1, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, {$urandom, $urandom}, 1'b0);
    checkOutput("ninth_word_err", err_overflow, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    sendIteration(1'b1, '0, 1'b0, 1'b0);
    drainAndCheck(0);
    checkOutput("err_sticky", err_overflow, 1'b1);
    pulseStart();
    checkOutput("err_cleared_by_start", err_overflow, 1'b0);

    // Random full-range data over 9 iterations, extra iter_done at the end, ready 1,0,0,1
    for (int it = 0; it < KIJ; it++) sendIteration(1'b1, '0, $urandom_range(0, 1) != 0, 1'b1);
    checkOutput("iter_done_last_err", err_overflow, m_err);
    drainAndCheck(1);

    // Lanes -5 for 9 iterations
    pulseStart();
    for (int it = 0; it < KIJ; it++) sendIteration(1'b0, {4{16'hFFFB}}, 1'b0, it < KIJ - 1);
    drainAndCheck(0);
`ifdef PSUM_ACC_RELU_EN
    checkOutput("neg45", got[5], 64'h0);
`else
    checkOutput("neg45", got[5], {4{16'hFFD3}});
`endif

    // Reset mid-accumulate
    pulseStart();
    applyStimulus(1'b1, {$urandom, $urandom}, 1'b0);
    applyStimulus(1'b1, {$urandom, $urandom}, 1'b0);
    doReset();
    checkOutput("rst_accum_busy", busy, 1'b0);
    checkOutput("rst_accum_err", err_overflow, 1'b0);

    // Reset mid-drain
    pulseStart();
    sendIteration(1'b1, '0, 1'b0, 1'b0);
    compute_done = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("pre_reset_valid", out_valid, 1'b1);
    compute_done = 1'b0;
    doReset();
    checkOutput("rst_drain_valid", out_valid, 1'b0);
    checkOutput("rst_drain_data", out_data, '0);
    checkOutput("rst_drain_last", out_last, 1'b0);
    checkOutput("rst_drain_busy", busy, 1'b0);

    // Randomized computes of varying length
    for (int n = 0; n < 4; n++) begin
      int iters;
      iters = $urandom_range(1, KIJ);
      pulseStart();
      for (int it = 0; it < iters; it++) sendIteration(1'b1, '0, $urandom_range(0, 1) != 0, it < iters - 1);
      checkOutput("rand_err", err_overflow, m_err);
      drainAndCheck(2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
